// File: rtl/qubit_gate_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qgate_pkg
//  Description : Shared gate codes and fixed-point helpers for the pipelined
//                single-qubit gate unit.
//  Revision    : 1.0  initial release
// ============================================================================
package qgate_pkg;

    // Run-time gate select codes
    localparam logic [2:0] GATE_I   = 3'd0;
    localparam logic [2:0] GATE_X   = 3'd1;
    localparam logic [2:0] GATE_Y   = 3'd2;
    localparam logic [2:0] GATE_Z   = 3'd3;
    localparam logic [2:0] GATE_H   = 3'd4;
    localparam logic [2:0] GATE_S   = 3'd5;
    localparam logic [2:0] GATE_T   = 3'd6;
    localparam logic [2:0] GATE_TDG = 3'd7;

    // round(2^frac / sqrt(2)) = round(sqrt(2^(2*frac-1))), found as the largest
    // x with (x - 1/2)^2 <= 2^(2*frac-1), i.e. 4x^2 - 4x + 1 <= 2^(2*frac+1).
    // Integer-only so it folds to a constant in any tool.
    function automatic int calc_c(input int frac);
        logic [63:0] x;
        logic [63:0] t;
        logic [63:0] lim;
        x   = 64'd0;
        lim = 64'd1 << (2 * frac + 1);
        for (int b = frac; b >= 0; b--) begin
            t = x | (64'd1 << b);
            if ((64'd4 * t * t - 64'd4 * t + 64'd1) <= lim) begin
                x = t;
            end
        end
        return int'(x);
    endfunction

    // Round half up, then drop frac fractional bits (arithmetic shift = floor)
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] v,
                                                       input int frac);
        logic signed [63:0] half;
        half = 64'sd1 <<< (frac - 1);
        return (v + half) >>> frac;
    endfunction

    // Clip to the signed range of a width-bit two's complement value
    function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v,
                                                    input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/qubit_gate_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : qubit_gate_pipe_if
//  Description : Input/output stream bundle of the single-qubit gate unit.
//                master = upstream sequencer + write-back side, slave = unit.
//  Revision    : 1.0  initial release
// ============================================================================
interface qubit_gate_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       gate_sel;
    logic [WIDTH-1:0] alpha_re;
    logic [WIDTH-1:0] alpha_im;
    logic [WIDTH-1:0] beta_re;
    logic [WIDTH-1:0] beta_im;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_alpha_re;
    logic [WIDTH-1:0] out_alpha_im;
    logic [WIDTH-1:0] out_beta_re;
    logic [WIDTH-1:0] out_beta_im;
    logic [2:0]       out_gate;
    logic             out_sat;
    logic [31:0]      op_count;

    modport master (
        output in_valid, gate_sel, alpha_re, alpha_im, beta_re, beta_im, out_ready,
        input  in_ready, out_valid, out_alpha_re, out_alpha_im, out_beta_re,
               out_beta_im, out_gate, out_sat, op_count
    );

    modport slave (
        input  in_valid, gate_sel, alpha_re, alpha_im, beta_re, beta_im, out_ready,
        output in_ready, out_valid, out_alpha_re, out_alpha_im, out_beta_re,
               out_beta_im, out_gate, out_sat, op_count
    );
endinterface
`default_nettype wire

// File: rtl/qubit_gate_pipe_round_sat.sv
`default_nettype none
// ============================================================================
//  Module      : qgate_round_sat
//  Description : Converts one 2*WIDTH+1 bit product back to Q(WIDTH-FRAC).FRAC
//                with round-half-up and saturation, flagging any clip.
//                Internal math is 64-bit, so WIDTH is limited to 31.
//  Revision    : 1.0  initial release
// ============================================================================
module qgate_round_sat
    import qgate_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  wire logic signed [2*WIDTH:0] i_prod,
    output logic             [WIDTH-1:0] o_res,
    output logic                         o_sat
);
    logic signed [63:0] w_ext;
    logic signed [63:0] w_rnd;
    logic signed [63:0] w_clip;

    assign w_ext  = {{(63 - 2 * WIDTH){i_prod[2*WIDTH]}}, i_prod};
    assign w_rnd  = round_shift(w_ext, FRAC);
    assign w_clip = sat_clip(w_rnd, WIDTH);
    assign o_res  = w_clip[WIDTH-1:0];
    assign o_sat  = (w_clip != w_rnd);

endmodule
`default_nettype wire

// File: rtl/qubit_gate_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : qubit_gate_pipe
//  Description : 3-stage pipelined single-qubit gate unit (I X Y Z H S T T+)
//                on a signed fixed-point amplitude pair, with a global
//                valid/ready stall, saturation flag and transfer counter.
//  Revision    : 1.0  initial release
// ============================================================================
module qubit_gate_pipe
    import qgate_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  wire           clk,
    input  wire           reset,
    qubit_gate_pipe_if.slave bus
);
    // Multipliers widened to the product width; both are positive
    localparam logic signed [2*WIDTH:0] c_coef_h   = (2 * WIDTH + 1)'(calc_c(FRAC));
    localparam logic signed [2*WIDTH:0] c_coef_one = (2 * WIDTH + 1)'(64'd1 << FRAC);

    logic                       w_en;
    logic signed [WIDTH:0]      w_are;
    logic signed [WIDTH:0]      w_aim;
    logic signed [WIDTH:0]      w_bre;
    logic signed [WIDTH:0]      w_bim;
    logic signed [WIDTH:0]      w_p0;
    logic signed [WIDTH:0]      w_p1;
    logic signed [WIDTH:0]      w_p2;
    logic signed [WIDTH:0]      w_p3;
    logic [3:0]                 w_scale;

    logic                       r_s1_valid;
    logic                       r_s2_valid;
    logic                       r_s3_valid;
    logic [2:0]                 r_s1_gate;
    logic [2:0]                 r_s2_gate;
    logic [2:0]                 r_s3_gate;
    logic [4*(WIDTH+1)-1:0]     r_s1_p;
    logic [3:0]                 r_s1_scale;
    logic [31:0]                r_op_count;

    logic [4*WIDTH-1:0]         w_s3_res;
    logic [3:0]                 w_s3_sat;

    // One shared stall: nothing moves while a result waits on downstream
    assign w_en = !r_s3_valid || bus.out_ready;

    // Sign-extend by one bit so sums, differences and negations are exact
    assign w_are = {bus.alpha_re[WIDTH-1], bus.alpha_re};
    assign w_aim = {bus.alpha_im[WIDTH-1], bus.alpha_im};
    assign w_bre = {bus.beta_re[WIDTH-1],  bus.beta_re};
    assign w_bim = {bus.beta_im[WIDTH-1],  bus.beta_im};

    // Stage 1 pre-products: lanes are 0=a_re 1=a_im 2=b_re 3=b_im; scale bit
    // set means the lane is later multiplied by 1/sqrt(2) instead of one
    always_comb begin
        w_p0    = w_are;
        w_p1    = w_aim;
        w_p2    = w_bre;
        w_p3    = w_bim;
        w_scale = 4'b0000;
        case (bus.gate_sel)
            GATE_I: begin
                w_p0 = w_are;
            end
            GATE_X: begin
                w_p0 = w_bre;
                w_p1 = w_bim;
                w_p2 = w_are;
                w_p3 = w_aim;
            end
            GATE_Y: begin
                w_p0 = w_bim;
                w_p1 = -w_bre;
                w_p2 = -w_aim;
                w_p3 = w_are;
            end
            GATE_Z: begin
                w_p2 = -w_bre;
                w_p3 = -w_bim;
            end
            GATE_H: begin
                w_p0    = w_are + w_bre;
                w_p1    = w_aim + w_bim;
                w_p2    = w_are - w_bre;
                w_p3    = w_aim - w_bim;
                w_scale = 4'b1111;
            end
            GATE_S: begin
                w_p2 = -w_bim;
                w_p3 = w_bre;
            end
            GATE_T: begin
                w_p2    = w_bre - w_bim;
                w_p3    = w_bre + w_bim;
                w_scale = 4'b1100;
            end
            GATE_TDG: begin
                w_p2    = w_bre + w_bim;
                w_p3    = w_bim - w_bre;
                w_scale = 4'b1100;
            end
            default: begin
                w_p0 = w_are;
            end
        endcase
    end

    // Stage 1 register: capture gate, pre-products and scale flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_gate  <= 3'd0;
            r_s1_p     <= '0;
            r_s1_scale <= 4'b0000;
        end else if (w_en) begin
            r_s1_valid <= bus.in_valid;
            r_s1_gate  <= bus.gate_sel;
            r_s1_p     <= {w_p3, w_p2, w_p1, w_p0};
            r_s1_scale <= w_scale;
        end
    end

    // Valid and gate tags travel alongside the data through stages 2 and 3
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
            r_s2_gate  <= 3'd0;
            r_s3_gate  <= 3'd0;
        end else if (w_en) begin
            r_s2_valid <= r_s1_valid;
            r_s3_valid <= r_s2_valid;
            r_s2_gate  <= r_s1_gate;
            r_s3_gate  <= r_s2_gate;
        end
    end

    // Count completed output transfers, wrapping naturally at 2^32
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op_count <= 32'd0;
        end else if (r_s3_valid && bus.out_ready) begin
            r_op_count <= r_op_count + 32'd1;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic signed [WIDTH:0]   w_p;
        logic signed [2*WIDTH:0] w_pext;
        logic signed [2*WIDTH:0] w_coef;
        logic signed [2*WIDTH:0] r_prod;
        logic [WIDTH-1:0]        w_res;
        logic                    w_sat;
        logic [WIDTH-1:0]        r_res;
        logic                    r_sat;

        assign w_p    = r_s1_p[i*(WIDTH+1) +: (WIDTH+1)];
        assign w_pext = {{WIDTH{w_p[WIDTH]}}, w_p};
        assign w_coef = r_s1_scale[i] ? c_coef_h : c_coef_one;

        // Stage 2: exact full-width product
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_prod <= '0;
            end else if (w_en) begin
                r_prod <= w_pext * w_coef;
            end
        end

        qgate_round_sat #(
            .WIDTH (WIDTH),
            .FRAC  (FRAC)
        ) u_round_sat (
            .i_prod (r_prod),
            .o_res  (w_res),
            .o_sat  (w_sat)
        );

        // Stage 3: hold the rounded, saturated component and its clip flag
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_res <= '0;
                r_sat <= 1'b0;
            end else if (w_en) begin
                r_res <= w_res;
                r_sat <= w_sat;
            end
        end

        assign w_s3_res[i*WIDTH +: WIDTH] = r_res;
        assign w_s3_sat[i]                = r_sat;
    end

    assign bus.in_ready     = w_en;
    assign bus.out_valid    = r_s3_valid;
    assign bus.out_alpha_re = w_s3_res[0*WIDTH +: WIDTH];
    assign bus.out_alpha_im = w_s3_res[1*WIDTH +: WIDTH];
    assign bus.out_beta_re  = w_s3_res[2*WIDTH +: WIDTH];
    assign bus.out_beta_im  = w_s3_res[3*WIDTH +: WIDTH];
    assign bus.out_gate     = r_s3_gate;
    assign bus.out_sat      = |w_s3_sat;
    assign bus.op_count     = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_qubit_gate_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qubit_gate_pipe
//  Description : Self-checking bench for qubit_gate_pipe (WIDTH=16, FRAC=8).
//                Expected results come from a complex-arithmetic model of the
//                eight gates evaluated with plain integers.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_qubit_gate_pipe;

    localparam int     WIDTH = 16;
    localparam int     FRAC  = 8;
    localparam longint C_H   = 181;   // round(256 / sqrt(2))
    localparam longint ONE   = 256;
    localparam int     N_RND = 300;

    typedef struct packed {
        logic [2:0]  g;
        logic [15:0] ar;
        logic [15:0] ai;
        logic [15:0] br;
        logic [15:0] bi;
        logic        sat;
    } res_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    qubit_gate_pipe_if #(.WIDTH(WIDTH)) bus ();

    qubit_gate_pipe #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: a' = Ka * va, b' = Kb * vb with K in {1, 1/sqrt2}, rounded half up
    function automatic res_t model(input logic [2:0] g, input logic [15:0] iar,
                                   input logic [15:0] iai, input logic [15:0] ibr,
                                   input logic [15:0] ibi);
        longint ar, ai, br, bi, t;
        longint v[4];
        longint k[4];
        logic [15:0] o[4];
        res_t r;
        ar = longint'($signed(iar));
        ai = longint'($signed(iai));
        br = longint'($signed(ibr));
        bi = longint'($signed(ibi));
        k  = '{ONE, ONE, ONE, ONE};
        case (g)
            3'd0: v = '{ar, ai, br, bi};
            3'd1: v = '{br, bi, ar, ai};
            3'd2: v = '{bi, -br, -ai, ar};
            3'd3: v = '{ar, ai, -br, -bi};
            3'd4: begin v = '{ar + br, ai + bi, ar - br, ai - bi}; k = '{C_H, C_H, C_H, C_H}; end
            3'd5: v = '{ar, ai, -bi, br};
            3'd6: begin v = '{ar, ai, br - bi, br + bi}; k[2] = C_H; k[3] = C_H; end
            default: begin v = '{ar, ai, br + bi, bi - br}; k[2] = C_H; k[3] = C_H; end
        endcase
        r.sat = 1'b0;
        for (int i = 0; i < 4; i++) begin
            t = (v[i] * k[i] + ONE / 2) >>> FRAC;
            if (t > 32767) begin
                t = 32767;
                r.sat = 1'b1;
            end else if (t < -32768) begin
                t = -32768;
                r.sat = 1'b1;
            end
            o[i] = t[15:0];
        end
        r.g  = g;
        r.ar = o[0];
        r.ai = o[1];
        r.br = o[2];
        r.bi = o[3];
        return r;
    endfunction

    function automatic res_t observe();
        return '{bus.out_gate, bus.out_alpha_re, bus.out_alpha_im,
                 bus.out_beta_re, bus.out_beta_im, bus.out_sat};
    endfunction

    function automatic string fmt(input res_t r);
        return $sformatf("g=%0d a=(%h,%h) b=(%h,%h) sat=%b", r.g, r.ar, r.ai, r.br, r.bi, r.sat);
    endfunction

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 7))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'h0000;
            3: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic drive(input logic v, input logic [2:0] g, input logic [15:0] ar,
                         input logic [15:0] ai, input logic [15:0] br, input logic [15:0] bi);
        bus.in_valid = v;
        bus.gate_sel = g;
        bus.alpha_re = ar;
        bus.alpha_im = ai;
        bus.beta_re  = br;
        bus.beta_im  = bi;
    endtask

    task automatic do_reset();
        drive(1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0);
        bus.out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        drive(1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0);
        bus.out_ready = 1'b0;
        #1 reset = 1'b0;
        #12;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.op_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: out_valid=%b op_count=%0d, required 0/0", bus.out_valid, bus.op_count);
        end
        n_cmp++;
        if (observe() !== res_t'(0)) begin
            n_fail++;
            $display("FAIL reset_data: got %s, required all zero", fmt(observe()));
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_idle: out_valid=%b in_ready=%b, required 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    // Single isolated transfer; lat counts rising edges from acceptance to out_valid
    task automatic send_one(input logic [2:0] g, input logic [15:0] ar, input logic [15:0] ai,
                            input logic [15:0] br, input logic [15:0] bi,
                            output res_t obs, output int lat);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        drive(1'b1, g, ar, ai, br, bi);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (bus.out_valid !== 1'b1 && lat < 12) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        obs = observe();
    endtask

    task automatic test_directed();
        logic [2:0]  tg[8];
        logic [15:0] ta[8][4];
        res_t        ex[8];
        res_t        obs;
        int          lat;
        do_reset();
        tg[0] = 3'd4; ta[0] = '{16'h0100, 16'h0, 16'h0, 16'h0};
        ex[0] = '{3'd4, 16'h00B5, 16'h0000, 16'h00B5, 16'h0000, 1'b0};
        tg[1] = 3'd4; ta[1] = '{16'h0, 16'h0, 16'h0100, 16'h0};
        ex[1] = '{3'd4, 16'h00B5, 16'h0000, 16'hFF4B, 16'h0000, 1'b0};
        tg[2] = 3'd1; ta[2] = '{16'h0, 16'h0, 16'h0100, 16'h0};
        ex[2] = '{3'd1, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        tg[3] = 3'd6; ta[3] = '{16'h0, 16'h0, 16'h0100, 16'h0};
        ex[3] = '{3'd6, 16'h0000, 16'h0000, 16'h00B5, 16'h00B5, 1'b0};
        tg[4] = 3'd5; ta[4] = '{16'h0, 16'h0, 16'h0100, 16'h0};
        ex[4] = '{3'd5, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 1'b0};
        tg[5] = 3'd2; ta[5] = '{16'h0100, 16'h0, 16'h0, 16'h0};
        ex[5] = '{3'd2, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 1'b0};
        tg[6] = 3'd3; ta[6] = '{16'h0, 16'h0, 16'h8000, 16'h0};
        ex[6] = '{3'd3, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 1'b1};
        tg[7] = 3'd4; ta[7] = '{16'h7FFF, 16'h0, 16'h7FFF, 16'h0};
        ex[7] = '{3'd4, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 1'b1};
        for (int i = 0; i < 8; i++) begin
            send_one(tg[i], ta[i][0], ta[i][1], ta[i][2], ta[i][3], obs, lat);
            n_cmp++;
            if (obs !== ex[i]) begin
                n_fail++;
                $display("FAIL directed_%0d: got %s, required %s", i, fmt(obs), fmt(ex[i]));
            end
            n_cmp++;
            if (lat != 3) begin
                n_fail++;
                $display("FAIL latency_%0d: got %0d cycles, required 3", i, lat);
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (bus.op_count !== 32'd8 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL directed_count: op_count=%0d out_valid=%b, required 8/0", bus.op_count, bus.out_valid);
        end
    endtask

    task automatic test_random();
        res_t q[$];
        int   sent = 0;
        int   rcv  = 0;
        int   dcyc = 0;
        int   ccyc = 0;
        do_reset();
        fork
            begin
                logic [2:0]  g;
                logic [15:0] d0, d1, d2, d3;
                while (sent < N_RND && dcyc < 20 * N_RND) begin
                    @(posedge clk); #1;
                    dcyc++;
                    g  = 3'($urandom);
                    d0 = rnd16(); d1 = rnd16(); d2 = rnd16(); d3 = rnd16();
                    drive(($urandom_range(0, 3) != 0), g, d0, d1, d2, d3);
                    @(negedge clk);
                    if (bus.in_valid && bus.in_ready) begin
                        q.push_back(model(g, d0, d1, d2, d3));
                        sent++;
                    end
                end
                @(posedge clk); #1;
                bus.in_valid = 1'b0;
            end
            begin
                res_t exp;
                while (rcv < N_RND && ccyc < 20 * N_RND) begin
                    @(posedge clk); #1;
                    ccyc++;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                    if (bus.out_valid && bus.out_ready) begin
                        n_cmp++;
                        if (q.size() == 0) begin
                            n_fail++;
                            $display("FAIL random_extra: unexpected output %s", fmt(observe()));
                        end else begin
                            exp = q.pop_front();
                            if (observe() !== exp) begin
                                n_fail++;
                                $display("FAIL random_%0d: got %s, required %s", rcv, fmt(observe()), fmt(exp));
                            end
                        end
                        rcv++;
                    end
                end
            end
        join
        n_cmp++;
        if (rcv != N_RND || sent != N_RND) begin
            n_fail++;
            $display("FAIL random_timeout: sent %0d received %0d, required %0d each", sent, rcv, N_RND);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (bus.op_count !== 32'(N_RND) || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL random_count: op_count=%0d out_valid=%b, required %0d/0", bus.op_count, bus.out_valid, N_RND);
        end
    endtask

    // Eight gates back to back; downstream stalls in cycles 4..6
    task automatic test_back_to_back();
        res_t        q[$];
        res_t        exp;
        logic [15:0] d[4];
        int          idx = 0;
        int          rcv = 0;
        int          cyc = 0;
        int          bad_rdy = 0;
        int          bad_hold = 0;
        do_reset();
        while (rcv < 8 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            bus.out_ready = (cyc < 4 || cyc > 6);
            for (int k = 0; k < 4; k++) d[k] = rnd16();
            drive((idx < 8), 3'(idx), d[0], d[1], d[2], d[3]);
            @(negedge clk);
            n_cmp++;
            if (bus.in_ready !== (cyc < 4 || cyc > 6)) begin
                n_fail++;
                bad_rdy++;
                $display("FAIL b2b_in_ready: cycle %0d got %b, required %b", cyc, bus.in_ready, (cyc < 4 || cyc > 6));
            end
            if (cyc >= 4 && cyc <= 6) begin
                n_cmp++;
                if (bus.out_valid !== 1'b1 || q.size() == 0 || observe() !== q[0]) begin
                    n_fail++;
                    bad_hold++;
                    $display("FAIL b2b_hold: cycle %0d out_valid=%b got %s", cyc, bus.out_valid, fmt(observe()));
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(3'(idx), d[0], d[1], d[2], d[3]));
                idx++;
            end
            if (bus.out_valid && bus.out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra: unexpected output %s", fmt(observe()));
                end else begin
                    exp = q.pop_front();
                    if (observe() !== exp) begin
                        n_fail++;
                        $display("FAIL b2b_%0d: got %s, required %s", rcv, fmt(observe()), fmt(exp));
                    end
                end
                rcv++;
            end
        end
        n_cmp++;
        if (rcv != 8) begin
            n_fail++;
            $display("FAIL b2b_timeout: received %0d, required 8", rcv);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.op_count !== 32'd8) begin
            n_fail++;
            $display("FAIL b2b_count: op_count=%0d, required 8", bus.op_count);
        end
    endtask

    task automatic test_reset_midstream();
        int seen = 0;
        do_reset();
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        drive(1'b1, 3'd4, 16'h0100, 16'h0, 16'h0, 16'h0);
        @(posedge clk); #1;
        drive(1'b1, 3'd1, 16'h0200, 16'h0, 16'h0300, 16'h0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_prefill: out_valid=%b, required 1", bus.out_valid);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.op_count !== 32'd0 || observe() !== res_t'(0)) begin
            n_fail++;
            $display("FAIL midreset_clear: out_valid=%b op_count=%0d got %s, required all zero",
                     bus.out_valid, bus.op_count, fmt(observe()));
        end
        @(negedge clk);
        reset = 1'b1;
        bus.out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0 || bus.op_count !== 32'd0) begin
            n_fail++;
            $display("FAIL midreset_flush: %0d stray valid cycles, op_count=%0d, required 0/0", seen, bus.op_count);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.out_ready = 1'b0;
        drive(1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0);
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
